// File: rtl/crc32_stream_engine_pkg.sv
// Shared constants, framing state type and CRC-32 table/keep helper functions
// for the streaming Ethernet FCS engine.
package crc32_pkg;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_e;

  function automatic logic [31:0] crc32_byte_entry(input logic [7:0] b);
    logic [31:0] t;
    t = {24'h000000, b};
    for (int i = 0; i < 8; i++) begin
      if (t[0]) t = {1'b0, t[31:1]} ^ CRC_POLY_REFL;
      else      t = {1'b0, t[31:1]};
    end
    return t;
  endfunction

  // Slice table k: the effect of byte idx followed by k zero bytes.
  function automatic logic [31:0] crc32_table(input int k, input int idx);
    logic [31:0] t;
    t = crc32_byte_entry(idx[7:0]);
    for (int i = 0; i < k; i++) begin
      t = {8'h00, t[31:8]} ^ crc32_byte_entry(t[7:0]);
    end
    return t;
  endfunction

  function automatic logic [3:0] keep_to_count(input logic [7:0] keep);
    logic [3:0] cnt;
    logic       run;
    cnt = 4'd0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (run && keep[i]) cnt = cnt + 4'd1;
      else                run = 1'b0;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/crc32_stream_engine_if.sv
// Beat-level stream bus of the CRC engine: inputs from the MAC datapath and
// the registered CRC/framing results back to it.
interface crc32_stream_engine_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int DATA_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_BYTES-1:0] i_keep;
  logic                  i_valid;
  logic                  i_sof;
  logic                  i_eof;
  logic [31:0]           o_crc_state;
  logic [31:0]           o_crc;
  logic                  o_crc_valid;
  logic                  o_crc_ok;
  logic                  o_in_frame;
  logic                  o_err;

  modport master (
    output i_data, i_keep, i_valid, i_sof, i_eof,
    input  o_crc_state, o_crc, o_crc_valid, o_crc_ok, o_in_frame, o_err
  );

  modport slave (
    input  i_data, i_keep, i_valid, i_sof, i_eof,
    output o_crc_state, o_crc, o_crc_valid, o_crc_ok, o_in_frame, o_err
  );
endinterface

// File: rtl/crc32_stream_engine_fold_comb.sv
// Combinational slicing-by-n CRC fold of the first `count` bytes of a beat,
// processed in 32-bit chunks so a 64-bit beat folds twice in one cycle.
module crc32_fold_comb
  import crc32_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           state,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [3:0]            count,
  output logic [31:0]           next_state
);
  localparam int NUM_CHUNKS = DATA_WIDTH / 32;

  logic [31:0] tbl_s [0:3][0:255];

  for (genvar k = 0; k < 4; k++) begin : g_tbl
    for (genvar i = 0; i < 256; i++) begin : g_idx
      localparam logic [31:0] ENTRY = crc32_table(k, i);
      assign tbl_s[k][i] = ENTRY;
    end
  end

  int          rem_s;
  int          cnt_s;
  logic [1:0]  tsel_s;
  logic [31:0] run_s;
  logic [31:0] acc_s;

  // Fold each 32-bit chunk; a chunk with no live bytes passes the state through.
  always_comb begin
    rem_s  = 0;
    cnt_s  = 0;
    tsel_s = 2'd0;
    acc_s  = 32'h0000_0000;
    run_s  = state;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      rem_s = int'(count) - 4 * c;
      cnt_s = (rem_s > 4) ? 4 : ((rem_s < 0) ? 0 : rem_s);
      acc_s = (cnt_s >= 4) ? 32'h0000_0000 : (run_s >> (8 * cnt_s));
      for (int j = 0; j < 4; j++) begin
        tsel_s = 2'(cnt_s - 1 - j);
        if (j < cnt_s) acc_s = acc_s ^ tbl_s[tsel_s][data[32*c + 8*j +: 8] ^ run_s[8*j +: 8]];
        else           acc_s = acc_s;
      end
      run_s = acc_s;
    end
    next_state = run_s;
  end

endmodule

// File: rtl/crc32_stream_engine.sv
// Frame-aware Ethernet CRC-32 engine: framing FSM, running CRC register,
// final FCS / residue check and protocol-error reporting.
module crc32_stream_engine
  import crc32_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  crc32_stream_engine_if.slave  bus
);
  frame_state_e fsm_r;
  frame_state_e fsm_next_s;
  logic [31:0]  crc_state_r;
  logic [31:0]  crc_r;
  logic         crc_ok_r;
  logic         crc_valid_r;
  logic         err_r;

  logic [7:0]   keep8_s;
  logic [3:0]   count_s;
  logic         accept_s;
  logic         noncontig_s;
  logic         partial_s;
  logic         process_s;
  logic         err_s;
  logic [31:0]  seed_s;
  logic [31:0]  fold_s;

  assign keep8_s     = 8'(bus.i_keep);
  assign count_s     = keep_to_count(keep8_s);
  assign accept_s    = bus.i_valid && (keep8_s != 8'h00);
  assign noncontig_s = (keep8_s >> count_s) != 8'h00;
  assign partial_s   = count_s != 4'(DATA_BYTES);
  assign seed_s      = bus.i_sof ? CRC_INIT : crc_state_r;

  crc32_fold_comb #(.DATA_WIDTH(DATA_WIDTH)) u_fold (
    .state      (seed_s),
    .data       (bus.i_data),
    .count      (count_s),
    .next_state (fold_s)
  );

  // Framing state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) fsm_r <= ST_IDLE;
    else         fsm_r <= fsm_next_s;
  end

  // Framing next-state, beat-processing decision and error detection.
  always_comb begin
    fsm_next_s = fsm_r;
    process_s  = 1'b0;
    err_s      = 1'b0;
    case (fsm_r)
      ST_IDLE: begin
        if (accept_s && bus.i_sof) begin
          process_s  = 1'b1;
          fsm_next_s = bus.i_eof ? ST_IDLE : ST_IN_FRAME;
        end else if (accept_s) begin
          err_s = 1'b1;
        end else begin
          fsm_next_s = ST_IDLE;
        end
      end
      ST_IN_FRAME: begin
        if (accept_s) begin
          process_s  = 1'b1;
          err_s      = bus.i_sof;
          fsm_next_s = bus.i_eof ? ST_IDLE : ST_IN_FRAME;
        end else begin
          fsm_next_s = ST_IN_FRAME;
        end
      end
      default: fsm_next_s = ST_IDLE;
    endcase
    if (process_s && (noncontig_s || (partial_s && !bus.i_eof))) err_s = 1'b1;
    else                                                         err_s = err_s;
  end

  // Running CRC, final FCS and status pulses; o_crc/o_crc_ok hold between frames.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      crc_state_r <= CRC_INIT;
      crc_r       <= 32'h0000_0000;
      crc_ok_r    <= 1'b0;
      crc_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      crc_valid_r <= process_s && bus.i_eof;
      err_r       <= err_s;
      if (process_s) crc_state_r <= fold_s;
      if (process_s && bus.i_eof) begin
        crc_r    <= ~fold_s;
        crc_ok_r <= (fold_s == CRC_RESIDUE);
      end
    end
  end

  assign bus.o_crc_state = crc_state_r;
  assign bus.o_crc       = crc_r;
  assign bus.o_crc_ok    = crc_ok_r;
  assign bus.o_crc_valid = crc_valid_r;
  assign bus.o_err       = err_r;
  assign bus.o_in_frame  = (fsm_r == ST_IN_FRAME);

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Self-checking bench: 32- and 64-bit engines against a bytewise CRC/framing model.
module tb_crc32_stream_engine;

  logic clk = 1'b0;
  logic rst32;
  logic rst64;
  always #5 clk = ~clk;

  crc32_stream_engine_if #(.DATA_WIDTH(32)) if32 ();
  crc32_stream_engine_if #(.DATA_WIDTH(64)) if64 ();

  crc32_stream_engine #(.DATA_WIDTH(32)) dut32 (.i_clk(clk), .i_reset(rst32), .bus(if32.slave));
  crc32_stream_engine #(.DATA_WIDTH(64)) dut64 (.i_clk(clk), .i_reset(rst64), .bus(if64.slave));

  typedef struct {
    logic [31:0] state;
    logic [31:0] crc;
    bit          ok;
    bit          in_frame;
    bit          err;
    bit          cv;
  } model_t;

  model_t m32;
  model_t m64;
  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Plain bit-serial reflected CRC over the first n bytes of d.
  function automatic logic [31:0] ref_crc(input logic [31:0] seed, input logic [63:0] d, input int n);
    logic [31:0] c;
    c = seed;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, d[8*i +: 8]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic model_t model_step(input model_t m, input logic [63:0] d, input logic [7:0] k,
                                        input bit v, input bit s, input bit e, input bit r, input int nb);
    model_t n;
    int cnt;
    int pop;
    n = m;
    if (r) begin
      n.state = 32'hFFFFFFFF; n.crc = 32'h0; n.ok = 0; n.in_frame = 0; n.err = 0; n.cv = 0;
      return n;
    end
    n.err = 0;
    n.cv  = 0;
    if (v && k != 8'h00) begin
      cnt = 0;
      while (cnt < nb && k[cnt]) cnt++;
      pop = 0;
      for (int i = 0; i < nb; i++) pop += int'(k[i]);
      if (s || m.in_frame) begin
        n.state = ref_crc(s ? 32'hFFFFFFFF : m.state, d, cnt);
        if ((s && m.in_frame) || pop != cnt || (cnt < nb && !e)) n.err = 1;
        if (e) begin
          n.in_frame = 0;
          n.cv       = 1;
          n.crc      = ~n.state;
          n.ok       = (n.state == 32'hDEBB20E3);
        end else begin
          n.in_frame = 1;
        end
      end else begin
        n.err = 1;
      end
    end
    return n;
  endfunction

  task automatic check_all();
    check_eq("state32", if32.o_crc_state, m32.state);
    check_eq("crc32",   if32.o_crc, m32.crc);
    check_eq("ok32",    32'(if32.o_crc_ok), 32'(m32.ok));
    check_eq("valid32", 32'(if32.o_crc_valid), 32'(m32.cv));
    check_eq("frame32", 32'(if32.o_in_frame), 32'(m32.in_frame));
    check_eq("err32",   32'(if32.o_err), 32'(m32.err));
    check_eq("state64", if64.o_crc_state, m64.state);
    check_eq("crc64",   if64.o_crc, m64.crc);
    check_eq("ok64",    32'(if64.o_crc_ok), 32'(m64.ok));
    check_eq("valid64", 32'(if64.o_crc_valid), 32'(m64.cv));
    check_eq("frame64", 32'(if64.o_in_frame), 32'(m64.in_frame));
    check_eq("err64",   32'(if64.o_err), 32'(m64.err));
  endtask

  task automatic idle_inputs();
    if32.i_data = 32'h0; if32.i_keep = 4'h0; if32.i_valid = 1'b0; if32.i_sof = 1'b0; if32.i_eof = 1'b0;
    if64.i_data = 64'h0; if64.i_keep = 8'h0; if64.i_valid = 1'b0; if64.i_sof = 1'b0; if64.i_eof = 1'b0;
    rst32 = 1'b0;
    rst64 = 1'b0;
  endtask

  // One clock with a beat (or reset) on the selected engine; the other idles.
  task automatic step(input int which, input logic [63:0] d, input logic [7:0] k,
                      input bit v, input bit s, input bit e, input bit r);
    idle_inputs();
    if (which == 0) begin
      if32.i_data = d[31:0]; if32.i_keep = k[3:0]; if32.i_valid = v; if32.i_sof = s; if32.i_eof = e;
      rst32 = r;
    end else begin
      if64.i_data = d; if64.i_keep = k; if64.i_valid = v; if64.i_sof = s; if64.i_eof = e;
      rst64 = r;
    end
    @(posedge clk);
    #1;
    if (which == 0) begin
      m32 = model_step(m32, {32'h0, d[31:0]}, {4'h0, k[3:0]}, v, s, e, r, 4);
      m64 = model_step(m64, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    end else begin
      m32 = model_step(m32, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4);
      m64 = model_step(m64, d, k, v, s, e, r, 8);
    end
    check_all();
  endtask

  initial begin
    logic [31:0] mid;
    idle_inputs();
    rst32 = 1'b1;
    rst64 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m32 = model_step(m32, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    m64 = model_step(m64, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    check_all();
    check_eq("rst_state", if32.o_crc_state, 32'hFFFFFFFF);

    // "123456789" on the 32-bit engine
    step(0, 64'h34333231, 8'h0F, 1, 1, 0, 0);
    step(0, 64'h38373635, 8'h0F, 1, 0, 0, 0);
    step(0, 64'h39,       8'h01, 1, 0, 1, 0);
    check_eq("check_w32", if32.o_crc, 32'hCBF43926);
    check_eq("check_w32_valid", 32'(if32.o_crc_valid), 32'h1);
    step(0, 64'h0, 8'h00, 0, 0, 0, 0);
    check_eq("crc_hold", if32.o_crc, 32'hCBF43926);

    // RX residue check with appended FCS, then one corrupted bit
    step(0, 64'h34333231, 8'h0F, 1, 1, 0, 0);
    step(0, 64'h38373635, 8'h0F, 1, 0, 0, 0);
    step(0, 64'hF4392639, 8'h0F, 1, 0, 0, 0);
    step(0, 64'hCB,       8'h01, 1, 0, 1, 0);
    check_eq("rx_ok", 32'(if32.o_crc_ok), 32'h1);
    check_eq("rx_residue", if32.o_crc_state, 32'hDEBB20E3);
    step(0, 64'h34333231, 8'h0F, 1, 1, 0, 0);
    step(0, 64'h38373635, 8'h0F, 1, 0, 0, 0);
    step(0, 64'hF4392638, 8'h0F, 1, 0, 0, 0);
    step(0, 64'hCB,       8'h01, 1, 0, 1, 0);
    check_eq("rx_bad", 32'(if32.o_crc_ok), 32'h0);

    // 64-bit engine: split fold and single-byte frame
    step(1, 64'h3837363534333231, 8'hFF, 1, 1, 0, 0);
    step(1, 64'h39,               8'h01, 1, 0, 1, 0);
    check_eq("check_w64", if64.o_crc, 32'hCBF43926);
    step(1, 64'h00, 8'h01, 1, 1, 1, 0);
    check_eq("zero_byte", if64.o_crc, 32'hD202EF8D);
    check_eq("single_frame", 32'(if64.o_in_frame), 32'h0);

    // Restart mid-frame
    step(0, 64'hAAAAAAAA, 8'h0F, 1, 1, 0, 0);
    step(0, 64'h34333231, 8'h0F, 1, 1, 0, 0);
    check_eq("restart_err", 32'(if32.o_err), 32'h1);
    step(0, 64'h38373635, 8'h0F, 1, 0, 0, 0);
    check_eq("restart_err_clr", 32'(if32.o_err), 32'h0);
    step(0, 64'h39, 8'h01, 1, 0, 1, 0);
    check_eq("restart_crc", if32.o_crc, 32'hCBF43926);

    // Reset mid-frame (with a colliding beat), then a stray beat
    step(0, 64'h34333231, 8'h0F, 1, 1, 0, 0);
    step(0, 64'h38373635, 8'h0F, 1, 0, 0, 1);
    check_eq("rst_mid_state", if32.o_crc_state, 32'hFFFFFFFF);
    check_eq("rst_mid_frame", 32'(if32.o_in_frame), 32'h0);
    step(0, 64'h39, 8'h01, 1, 0, 1, 0);
    check_eq("stray_err", 32'(if32.o_err), 32'h1);
    check_eq("stray_valid", 32'(if32.o_crc_valid), 32'h0);
    check_eq("stray_state", if32.o_crc_state, 32'hFFFFFFFF);

    // Empty keep inside a frame, then non-contiguous keep
    step(0, 64'h34333231, 8'h0F, 1, 1, 0, 0);
    mid = ref_crc(32'hFFFFFFFF, 64'h34333231, 4);
    step(0, 64'h12345678, 8'h00, 1, 0, 0, 0);
    check_eq("keep0_state", if32.o_crc_state, mid);
    check_eq("keep0_err", 32'(if32.o_err), 32'h0);
    step(0, 64'h00550035, 8'h05, 1, 0, 1, 0);
    check_eq("noncontig_err", 32'(if32.o_err), 32'h1);
    check_eq("noncontig_state", if32.o_crc_state, ref_crc(mid, 64'h35, 1));

    // Randomized traffic on both engines
    for (int it = 0; it < 600; it++) begin
      int which, nb, kind, n;
      bit inf, v, s, e, r;
      logic [63:0] d;
      logic [7:0] k;
      which = $urandom_range(0, 1);
      nb    = (which == 1) ? 8 : 4;
      inf   = (which == 1) ? m64.in_frame : m32.in_frame;
      d     = {$urandom, $urandom};
      v     = ($urandom_range(0, 9) != 0);
      s     = inf ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) != 0);
      e     = ($urandom_range(0, 3) == 0);
      r     = ($urandom_range(0, 99) == 0);
      kind  = $urandom_range(0, 19);
      if (kind < 14) begin
        k = (nb == 8) ? 8'hFF : 8'h0F;
      end else if (kind < 17) begin
        n = $urandom_range(1, nb);
        k = 8'((16'd1 << n) - 16'd1);
      end else begin
        k = 8'($urandom_range(0, (1 << nb) - 1));
      end
      step(which, d, k, v, s, e, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
